gray_counter: RTL and testbench

//  Registered up/down counter that keeps a binary count and emits the matching Gray code from flops.

---
 rtl/gray_pkg.sv | 26 ++
 rtl/gray_next_calc.sv | 71 +++++++
 rtl/gray_counter.sv | 63 ++++++
 tb/tb_gray_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and helpers for the registered Gray-code counter.
// Provides bin2gray, an all-ones limit helper and the step-kind enum.
package gray_pkg;

   localparam int MAX_W = 32;

   typedef logic [MAX_W-1:0] word_t;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_LOAD,
      STEP_UP,
      STEP_DN
   } step_e;

   function automatic word_t bin2gray(input word_t b);
      return b ^ (b >> 1);
   endfunction

   // All-ones value for a w-bit counter (w in 2..32).
   function automatic word_t max_val(input int w);
      if (w >= MAX_W) return '1;
      return (word_t'(1) << w) - word_t'(1);
   endfunction

endpackage

// File: rtl/gray_next_calc.sv
// Combinational next-state logic: next binary, next Gray and wrap flag.
// Ports: i_bin (current count), i_en, i_up, i_load, i_load_bin -> o_next_*.
module gray_next_calc
   import gray_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter bit SATURATE   = 1'b0
) (
   input  logic [DATA_WIDTH-1:0] i_bin,
   input  logic                  i_en,
   input  logic                  i_up,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_load_bin,
   output logic [DATA_WIDTH-1:0] o_next_bin,
   output logic [DATA_WIDTH-1:0] o_next_gray,
   output logic                  o_next_wrap
);

   localparam logic [DATA_WIDTH-1:0] MAX =
      DATA_WIDTH'(max_val(DATA_WIDTH));
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   step_e                  w_kind;
   logic                   w_at_max;
   logic                   w_at_zero;
   logic [DATA_WIDTH-1:0]  w_bin;
   logic                   w_wrap;

   assign w_at_max  = (i_bin == MAX);
   assign w_at_zero = (i_bin == '0);

   // Load beats a step; en only matters when not loading.
   always_comb begin
      w_kind = STEP_HOLD;
      if (i_load)
         w_kind = STEP_LOAD;
      else if (i_en)
         w_kind = i_up ? STEP_UP : STEP_DN;
   end

   always_comb begin
      w_bin  = i_bin;
      w_wrap = 1'b0;
      case (w_kind)
         STEP_LOAD: w_bin = i_load_bin;
         STEP_UP: begin
            if (!w_at_max)
               w_bin = i_bin + ONE;
            else if (!SATURATE) begin
               w_bin  = '0;
               w_wrap = 1'b1;
            end
         end
         STEP_DN: begin
            if (!w_at_zero)
               w_bin = i_bin - ONE;
            else if (!SATURATE) begin
               w_bin  = MAX;
               w_wrap = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Gray is derived from the next binary value so both flops load together.
   assign o_next_bin  = w_bin;
   assign o_next_gray = DATA_WIDTH'(bin2gray(word_t'(w_bin)));
   assign o_next_wrap = w_wrap;

endmodule

// File: rtl/gray_counter.sv
// Registered up/down counter with glitch-free registered Gray output.
// Ports: clk, rst_n, en, up, load, load_bin -> out_bin, out_gray, wrap, at_limit.
module gray_counter
   import gray_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter bit SATURATE   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_bin,
   output logic [DATA_WIDTH-1:0] out_bin,
   output logic [DATA_WIDTH-1:0] out_gray,
   output logic                  wrap,
   output logic                  at_limit
);

   localparam logic [DATA_WIDTH-1:0] MAX =
      DATA_WIDTH'(max_val(DATA_WIDTH));

   logic [DATA_WIDTH-1:0] r_bin;
   logic [DATA_WIDTH-1:0] r_gray;
   logic                  r_wrap;

   logic [DATA_WIDTH-1:0] w_next_bin;
   logic [DATA_WIDTH-1:0] w_next_gray;
   logic                  w_next_wrap;

   gray_next_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
   ) u_next (
      .i_bin       (r_bin),
      .i_en        (en),
      .i_up        (up),
      .i_load      (load),
      .i_load_bin  (load_bin),
      .o_next_bin  (w_next_bin),
      .o_next_gray (w_next_gray),
      .o_next_wrap (w_next_wrap)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_next_bin;
         r_gray <= w_next_gray;
         r_wrap <= w_next_wrap;
      end
   end

   assign out_bin  = r_bin;
   assign out_gray = r_gray;
   assign wrap     = r_wrap;
   assign at_limit = up ? (r_bin == MAX) : (r_bin == '0);

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: wrapping and saturating instances.
// Both share stimulus and are compared against an arithmetic model.
module tb_gray_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_bin;

   logic [3:0] bin0, gray0, bin1, gray1;
   logic       wrap0, lim0, wrap1, lim1;

   int total = 0;
   int bad   = 0;

   int m_bin  [2];
   bit m_wrap [2];

   always #5 clk = ~clk;

   gray_counter #(.DATA_WIDTH(4), .SATURATE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up),
      .load(load), .load_bin(load_bin),
      .out_bin(bin0), .out_gray(gray0),
      .wrap(wrap0), .at_limit(lim0)
   );

   gray_counter #(.DATA_WIDTH(4), .SATURATE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up),
      .load(load), .load_bin(load_bin),
      .out_bin(bin1), .out_gray(gray1),
      .wrap(wrap1), .at_limit(lim1)
   );

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   // Expected {bin, gray, wrap, at_limit} for model s under current up.
   function automatic logic [9:0] expv(input int s);
      logic [3:0] b;
      logic [3:0] g;
      logic       l;
      b = 4'(m_bin[s]);
      g = 4'(gray_of(m_bin[s]));
      l = up ? (m_bin[s] == 15) : (m_bin[s] == 0);
      return {b, g, m_wrap[s], l};
   endfunction

   function automatic int popc(input logic [3:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
   endfunction

   // Drive one cycle and advance the model using the spec's rules.
   task automatic cyc(input logic r, input logic e, input logic u,
                      input logic l, input logic [3:0] lb);
      rst_n = r; en = e; up = u; load = l; load_bin = lb;
      @(posedge clk);
      for (int s = 0; s < 2; s++) begin
         m_wrap[s] = 1'b0;
         if (!r) m_bin[s] = 0;
         else if (l) m_bin[s] = int'(lb);
         else if (e && u) begin
            if (m_bin[s] < 15) m_bin[s] = m_bin[s] + 1;
            else if (s == 0) begin m_bin[s] = 0; m_wrap[s] = 1'b1; end
         end else if (e) begin
            if (m_bin[s] > 0) m_bin[s] = m_bin[s] - 1;
            else if (s == 0) begin m_bin[s] = 15; m_wrap[s] = 1'b1; end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'hA);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
         total++;
         if ({bin0, gray0, wrap0} !== 9'd0) begin
            bad++;
            $display("FAIL reset got=%h exp=000", {bin0, gray0, wrap0});
         end
         total++;
         if ({bin1, gray1, wrap1} !== 9'd0) begin
            bad++;
            $display("FAIL reset_sat got=%h exp=000", {bin1, gray1, wrap1});
         end
      end
   endtask

   task automatic test_count_up();
      logic [3:0] gtab [16];
      logic [3:0] g_old;
      gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      for (int i = 0; i < 16; i++) begin
         g_old = gray0;
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
         total++;
         if (gray0 !== gtab[i] || wrap0 !== (i == 15)) begin
            bad++;
            $display("FAIL up_seq[%0d] got=%h/%b exp=%h/%b",
                     i, gray0, wrap0, gtab[i], (i == 15));
         end
         total++;
         if (popc(g_old ^ gray0) != 1) begin
            bad++;
            $display("FAIL up_onebit[%0d] got=%0d exp=1",
                     i, popc(g_old ^ gray0));
         end
      end
   endtask

   task automatic test_count_down();
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      total++;
      if ({bin0, gray0, wrap0} !== {4'hF, 4'h8, 1'b1}) begin
         bad++;
         $display("FAIL down_wrap got=%h exp=%h",
                  {bin0, gray0, wrap0}, {4'hF, 4'h8, 1'b1});
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      total++;
      if ({bin0, gray0, wrap0} !== {4'hE, 4'h9, 1'b0}) begin
         bad++;
         $display("FAIL down_next got=%h exp=%h",
                  {bin0, gray0, wrap0}, {4'hE, 4'h9, 1'b0});
      end
   endtask

   task automatic test_load();
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'hA);
      total++;
      if ({bin0, gray0, wrap0} !== {4'hA, 4'hF, 1'b0}) begin
         bad++;
         $display("FAIL load got=%h exp=%h",
                  {bin0, gray0, wrap0}, {4'hA, 4'hF, 1'b0});
      end
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      total++;
      if ({bin0, gray0, wrap0} !== {4'hB, 4'hE, 1'b0}) begin
         bad++;
         $display("FAIL load_step got=%h exp=%h",
                  {bin0, gray0, wrap0}, {4'hB, 4'hE, 1'b0});
      end
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'h6);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h9);
      total++;
      if ({bin0, gray0, wrap0, bin1, gray1, wrap1} !== 18'd0) begin
         bad++;
         $display("FAIL reset_mid got=%h exp=0",
                  {bin0, gray0, wrap0, bin1, gray1, wrap1});
      end
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      total++;
      if ({bin0, gray0} !== {4'h1, 4'h1}) begin
         bad++;
         $display("FAIL resume got=%h exp=11", {bin0, gray0});
      end
   endtask

   task automatic test_saturate();
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'hE);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
         total++;
         if ({bin1, wrap1, lim1} !== {4'hF, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sat_hold[%0d] got=%h exp=%h",
                     i, {bin1, wrap1, lim1}, {4'hF, 1'b0, 1'b1});
         end
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      total++;
      if ({bin1, gray1, lim1} !== {4'hE, 4'h9, 1'b0}) begin
         bad++;
         $display("FAIL sat_down got=%h exp=%h",
                  {bin1, gray1, lim1}, {4'hE, 4'h9, 1'b0});
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      total++;
      if ({bin1, wrap1, lim1} !== {4'h0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL sat_zero got=%h exp=%h",
                  {bin1, wrap1, lim1}, {4'h0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_random();
      logic [9:0] e;
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 39) != 0),
             ($urandom_range(0, 3) != 0),
             1'($urandom),
             ($urandom_range(0, 9) == 0),
             4'($urandom));
         // Occasionally flip direction between edges to check at_limit.
         if ($urandom_range(0, 3) == 0) begin
            up = ~up;
            #1;
         end
         e = expv(0);
         total++;
         if ({bin0, gray0, wrap0, lim0} !== e) begin
            bad++;
            $display("FAIL rand_wrap[%0d] got=%h exp=%h",
                     i, {bin0, gray0, wrap0, lim0}, e);
         end
         e = expv(1);
         total++;
         if ({bin1, gray1, wrap1, lim1} !== e) begin
            bad++;
            $display("FAIL rand_sat[%0d] got=%h exp=%h",
                     i, {bin1, gray1, wrap1, lim1}, e);
         end
      end
   endtask

   initial begin
      m_bin  = '{0, 0};
      m_wrap = '{1'b0, 1'b0};
      rst_n = 1'b0; en = 1'b0; up = 1'b1;
      load = 1'b0; load_bin = 4'h0;
      test_reset();
      test_count_up();
      test_count_down();
      test_load();
      test_reset_mid();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
